// File: rtl/vector_wom_writer.sv
// vector_wom_writer: buffers 4-lane x 32-bit vectors from vector_cpu in a
// small FIFO and serializes them into one 32-bit WOM write per cycle at
// consecutive addresses from a programmed base, pulsing done after the
// programmed number of words.
module vector_wom_writer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active low
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] n_words,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] lane0,
    input  logic [31:0] lane1,
    input  logic [31:0] lane2,
    input  logic [31:0] lane3,
    output logic        wom_we,
    output logic [31:0] wom_addr,
    output logic [31:0] wom_wd,
    output logic        busy,
    output logic        done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [31:0]      base_q,   base_d;
    logic [31:0]      remain_q, remain_d;
    logic [31:0]      wcnt_q,   wcnt_d;
    logic [1:0]       lane_q,   lane_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Vector storage; lane0 occupies the least significant 32 bits.
    logic [127:0] fifo_q [FIFO_DEPTH];
    logic [31:0]  head_lane [4];

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic write;
    logic last_write;
    logic pop;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Readiness depends only on occupancy, never on a same-cycle pop.
    assign in_ready   = (state_q == ST_RUN) && !fifo_full;
    assign wom_we     = (state_q == ST_RUN) && !fifo_empty;
    assign push       = in_valid && in_ready;
    assign write      = wom_we;
    assign last_write = write && (remain_q == 32'd1);
    // The head leaves after its lane 3 or when the job ends mid-vector.
    assign pop        = write && ((lane_q == 2'd3) || last_write);

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_head_lane
            assign head_lane[gi] = fifo_q[rd_ptr_q][gi*32 +: 32];
        end
    endgenerate

    // Address and data are held at zero whenever no write is presented.
    assign wom_addr = wom_we ? (base_q + wcnt_q) : 32'd0;
    assign wom_wd   = wom_we ? head_lane[lane_q] : 32'd0;

    // Next-state logic for the job FSM, counters and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        remain_d = remain_q;
        wcnt_d   = wcnt_q;
        lane_d   = lane_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    remain_d = n_words;
                    wcnt_d   = 32'd0;
                    lane_d   = 2'd0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = (n_words == 32'd0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (push) begin
                    wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                if (write) begin
                    wcnt_d   = wcnt_q + 32'd1;
                    remain_d = remain_q - 32'd1;
                    lane_d   = lane_q + 2'd1;
                end
                // Job complete: drop leftover lanes and any queued vectors.
                if (last_write) begin
                    state_d  = ST_DONE;
                    lane_d   = 2'd0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            base_q   <= 32'd0;
            remain_q <= 32'd0;
            wcnt_q   <= 32'd0;
            lane_q   <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            remain_q <= remain_d;
            wcnt_q   <= wcnt_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Vector storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {lane3, lane2, lane1, lane0};
        end
    end

endmodule

// File: tb/tb_vector_wom_writer.sv
// Directed self-checking bench for vector_wom_writer.
module tb_vector_wom_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] n_words;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] lane0, lane1, lane2, lane3;
    logic        wom_we;
    logic [31:0] wom_addr;
    logic [31:0] wom_wd;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    int done_cnt;
    int done_cyc;
    int last_we_cyc;

    vector_wom_writer #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .n_words   (n_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lane0     (lane0),
        .lane1     (lane1),
        .lane2     (lane2),
        .lane3     (lane3),
        .wom_we    (wom_we),
        .wom_addr  (wom_addr),
        .wom_wd    (wom_wd),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wom_we === 1'b1) begin
            wa_q.push_back(wom_addr);
            wd_q.push_back(wom_wd);
            last_we_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        last_we_cyc = -1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] n);
        start     = 1'b1;
        base_addr = b;
        n_words   = n;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic push_vec(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3,
                            output bit ok);
        in_valid = 1'b1;
        lane0 = a0; lane1 = a1; lane2 = a2; lane3 = a3;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [69:0] outs;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            base_addr = $urandom;
            n_words   = $urandom;
            lane0 = $urandom; lane1 = $urandom; lane2 = $urandom; lane3 = $urandom;
            @(negedge clk);
            outs = {in_ready, wom_we, wom_addr, wom_wd, busy, done};
            tests++;
            if (outs !== 70'd0) begin
                fails++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", i, outs);
            end
        end
        start = 1'b0; in_valid = 1'b0; base_addr = '0; n_words = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_mon();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle[%0d]: got ready=%b busy=%b expected 0 0", i, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (wd_q.size() != 0) begin
            fails++;
            $display("FAIL post_reset_no_write: got %0d writes expected 0", wd_q.size());
        end
    endtask

    task automatic test_basic();
        bit ok1, ok2, okd;
        logic [31:0] e [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        clear_mon();
        do_start(32'h100, 32'd8);
        push_vec(32'h11, 32'h22, 32'h33, 32'h44, ok1);
        push_vec(32'h55, 32'h66, 32'h77, 32'h88, ok2);
        wait_done(okd);
        tests++;
        if (!(ok1 && ok2 && okd)) begin
            fails++;
            $display("FAIL basic_handshake: got push=%b%b done=%b expected 111", ok1, ok2, okd);
        end
        tests++;
        if (wd_q.size() != 8) begin
            fails++;
            $display("FAIL basic_count: got %0d writes expected 8", wd_q.size());
        end
        for (int i = 0; i < 8 && i < wd_q.size(); i++) begin
            tests++;
            if (wa_q[i] !== 32'h100 + i || wd_q[i] !== e[i]) begin
                fails++;
                $display("FAIL basic_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 32'h100 + i, e[i]);
            end
        end
        tests++;
        if (done_cyc != last_we_cyc + 1 || done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done_timing: got done_cyc=%0d pulses=%0d expected cyc=%0d pulses=1",
                     done_cyc, done_cnt, last_we_cyc + 1);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_after: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2, ok3, okd;
        logic [31:0] exp;
        clear_mon();
        do_start(32'h300, 32'd12);
        push_vec(32'h0B000000, 32'h0B000001, 32'h0B000002, 32'h0B000003, ok1);
        push_vec(32'h0B000100, 32'h0B000101, 32'h0B000102, 32'h0B000103, ok2);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_full: got in_ready=%b expected 0", in_ready);
        end
        push_vec(32'h0B000200, 32'h0B000201, 32'h0B000202, 32'h0B000203, ok3);
        wait_done(okd);
        tests++;
        if (!(ok1 && ok2 && ok3 && okd) || wd_q.size() != 12) begin
            fails++;
            $display("FAIL bp_count: got push=%b%b%b done=%b writes=%0d expected 1111 12",
                     ok1, ok2, ok3, okd, wd_q.size());
        end
        for (int i = 0; i < 12 && i < wd_q.size(); i++) begin
            exp = 32'h0B000000 | (32'(i / 4) << 8) | 32'(i % 4);
            tests++;
            if (wa_q[i] !== 32'h300 + i || wd_q[i] !== exp) begin
                fails++;
                $display("FAIL bp_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 32'h300 + i, exp);
            end
        end
    endtask

    task automatic test_partial();
        bit ok1, ok2, ok3, okd;
        logic [31:0] exp;
        clear_mon();
        do_start(32'h500, 32'd6);
        push_vec(32'h0C000000, 32'h0C000001, 32'h0C000002, 32'h0C000003, ok1);
        push_vec(32'h0C000100, 32'h0C000101, 32'h0C000102, 32'h0C000103, ok2);
        push_vec(32'h0C000200, 32'h0C000201, 32'h0C000202, 32'h0C000203, ok3);
        wait_done(okd);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (!okd || wd_q.size() != 6 || done_cnt != 1) begin
            fails++;
            $display("FAIL partial_count: got done=%b writes=%0d pulses=%0d expected 1 6 1",
                     okd, wd_q.size(), done_cnt);
        end
        for (int i = 0; i < 6 && i < wd_q.size(); i++) begin
            exp = 32'h0C000000 | (32'(i / 4) << 8) | 32'(i % 4);
            tests++;
            if (wa_q[i] !== 32'h500 + i || wd_q[i] !== exp) begin
                fails++;
                $display("FAIL partial_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 32'h500 + i, exp);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        do_start(32'h700, 32'd0);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b1 || wom_we !== 1'b0) begin
            fails++;
            $display("FAIL zero_done_cycle1: got done=%b busy=%b we=%b expected 1 1 0", done, busy, wom_we);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle_cycle2: got done=%b busy=%b expected 0 0", done, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (wd_q.size() != 0) begin
            fails++;
            $display("FAIL zero_no_write: got %0d writes expected 0", wd_q.size());
        end
    endtask

    task automatic test_ignored_start();
        bit ok1, okd;
        clear_mon();
        do_start(32'h200, 32'd4);
        push_vec(32'h0D000000, 32'h0D000001, 32'h0D000002, 32'h0D000003, ok1);
        do_start(32'h900, 32'd100);
        wait_done(okd);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (!okd || wd_q.size() != 4 || done_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ign_start_count: got done=%b writes=%0d pulses=%0d busy=%b expected 1 4 1 0",
                     okd, wd_q.size(), done_cnt, busy);
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            tests++;
            if (wa_q[i] !== 32'h200 + i || wd_q[i] !== 32'h0D000000 + i) begin
                fails++;
                $display("FAIL ign_start_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         i, wa_q[i], wd_q[i], 32'h200 + i, 32'h0D000000 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2;
        logic [69:0] outs;
        clear_mon();
        do_start(32'h40, 32'd8);
        push_vec(32'h0E000000, 32'h0E000001, 32'h0E000002, 32'h0E000003, ok1);
        push_vec(32'h0E000100, 32'h0E000101, 32'h0E000102, 32'h0E000103, ok2);
        for (int i = 0; i < 50; i++) begin
            if (wd_q.size() >= 3) break;
            @(posedge clk); #1;
        end
        tests++;
        if (wom_we !== 1'b1) begin
            fails++;
            $display("FAIL mid_active_before_rst: got we=%b expected 1", wom_we);
        end
        #2 rst = 1'b0;
        #1;
        outs = {in_ready, wom_we, wom_addr, wom_wd, busy, done};
        tests++;
        if (outs !== 70'd0) begin
            fails++;
            $display("FAIL mid_rst_outputs: got %h expected 0", outs);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (wd_q.size() != 3 || busy !== 1'b0 || done_cnt != 0) begin
            fails++;
            $display("FAIL mid_rst_writes: got writes=%0d busy=%b pulses=%0d expected 3 0 0",
                     wd_q.size(), busy, done_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok1, okd;
        logic [31:0] ea [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        clear_mon();
        do_start(32'hFFFFFFFE, 32'd4);
        push_vec(32'hF0, 32'hF1, 32'hF2, 32'hF3, ok1);
        wait_done(okd);
        tests++;
        if (!okd || wd_q.size() != 4) begin
            fails++;
            $display("FAIL wrap_count: got done=%b writes=%0d expected 1 4", okd, wd_q.size());
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            tests++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== 32'hF0 + i) begin
                fails++;
                $display("FAIL wrap_write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                         i, wa_q[i], wd_q[i], ea[i], 32'hF0 + i);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        base_addr = '0; n_words = '0;
        lane0 = '0; lane1 = '0; lane2 = '0; lane3 = '0;
        clear_mon();
        #2;
        test_reset();
        test_basic();
        test_backpressure();
        test_partial();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
